// File: rtl/qcs_pkg.sv
// Instruction format shared by the scheduler's first register layer and the dispatch stage.
package qcs_pkg;

    localparam int DEF_NUM_FPGA           = 64;
    localparam int DEF_NUM_QUBIT_PER_FPGA = 64;
    localparam int DEF_TS_W               = 16;

    function automatic int qcs_qw(input int num_fpga, input int num_qubit_per_fpga);
        return $clog2(num_fpga * num_qubit_per_fpga);
    endfunction

    function automatic int qcs_iw(input int qw, input int ts_w);
        return 2 + 3 * qw + ts_w;
    endfunction

    // Field LSB offsets; start_time sits at bit 0, op_code at the top.
    function automatic int qcs_dest_lsb(input int qw, input int ts_w);
        return ts_w + 0 * qw;
    endfunction

    function automatic int qcs_op2_lsb(input int qw, input int ts_w);
        return ts_w + 1 * qw;
    endfunction

    function automatic int qcs_op1_lsb(input int qw, input int ts_w);
        return ts_w + 2 * qw;
    endfunction

    function automatic int qcs_opc_lsb(input int qw, input int ts_w);
        return ts_w + 3 * qw;
    endfunction

    localparam int QW        = qcs_qw(DEF_NUM_FPGA, DEF_NUM_QUBIT_PER_FPGA);
    localparam int IW        = qcs_iw(QW, DEF_TS_W);
    localparam int START_LSB = 0;
    localparam int DEST_LSB  = qcs_dest_lsb(QW, DEF_TS_W);
    localparam int OP2_LSB   = qcs_op2_lsb(QW, DEF_TS_W);
    localparam int OP1_LSB   = qcs_op1_lsb(QW, DEF_TS_W);
    localparam int OPC_LSB   = qcs_opc_lsb(QW, DEF_TS_W);

    typedef enum logic [1:0] {
        OP_SQG     = 2'd0,
        OP_TQG     = 2'd1,
        OP_MEAS    = 2'd2,
        OP_BARRIER = 2'd3
    } qcs_op_e;

    typedef struct packed {
        qcs_op_e                 op_code;
        logic [QW-1:0]           op_1;
        logic [QW-1:0]           op_2;
        logic [QW-1:0]           dest;
        logic [DEF_TS_W-1:0]     start_time;
    } qcs_instr_t;

endpackage

// File: rtl/qcs_fu_slot.sv
// One functional-unit output register with valid/ready handshake: load, hold, clear.
module qcs_fu_slot
    import qcs_pkg::*;
#(
    parameter int INSTR_W = IW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_free
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A slot being drained this cycle can take a new grant with no bubble.
    assign o_free  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_instr = r_instr;

endmodule

// File: rtl/qcs_dispatch_arbiter.sv
// Dispatch stage: buffers decoded gates, grants time-eligible, qubit-disjoint gates to free FU slots.
module qcs_dispatch_arbiter
    import qcs_pkg::*;
#(
    parameter int NUM_FPGA           = 64,
    parameter int NUM_QUBIT_PER_FPGA = 64,
    parameter int DEPTH              = 8,
    parameter int NUM_FU             = 4,
    parameter int TS_W               = 16,
    localparam int QBW     = qcs_qw(NUM_FPGA, NUM_QUBIT_PER_FPGA),
    localparam int INSTR_W = qcs_iw(QBW, TS_W),
    localparam int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INSTR_W-1:0]              in_instr,
    output logic [NUM_FU-1:0]               fu_valid,
    input  logic [NUM_FU-1:0]               fu_ready,
    output logic [NUM_FU-1:0][INSTR_W-1:0]  fu_instr,
    input  logic                            ts_adv_en,
    output logic [TS_W-1:0]                 curr_ts,
    output logic [OCC_W-1:0]                occupancy,
    output logic                            idle
);

    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DEST_OFS = qcs_dest_lsb(QBW, TS_W);
    localparam int OP2_OFS  = qcs_op2_lsb(QBW, TS_W);
    localparam int OP1_OFS  = qcs_op1_lsb(QBW, TS_W);

    logic [DEPTH-1:0]   r_valid;
    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [TS_W-1:0]    r_ts;
    logic [OCC_W-1:0]   r_occ;

    logic [DEPTH-1:0]   w_elig;
    logic [DEPTH-1:0]   w_grant;
    logic [DEPTH-1:0]   w_ins_mask;
    logic [QBW-1:0]     w_q [DEPTH][3];
    logic [NUM_FU-1:0]  w_slot_free;
    logic [NUM_FU-1:0]  w_load;
    logic [IDX_W-1:0]   w_load_sel [NUM_FU];
    logic [INSTR_W-1:0] w_load_instr [NUM_FU];
    logic [OCC_W-1:0]   w_grant_cnt;
    logic [IDX_W-1:0]   w_ins_idx;
    logic               w_ins;
    logic               w_ts_adv;

    assign in_ready  = (r_occ < OCC_W'(DEPTH));
    assign w_ins     = in_valid & in_ready;
    assign curr_ts   = r_ts;
    assign occupancy = r_occ;
    assign idle      = (r_occ == '0) & ~(|fu_valid);
    assign w_ts_adv  = ts_adv_en & ~(|w_elig) & ~(|fu_valid);

    always_comb begin
        w_ins_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!r_valid[i]) w_ins_idx = IDX_W'(i);
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [TS_W-1:0] w_diff;
        // Serial-number compare: due now or already late, robust across timestamp wrap.
        assign w_diff        = r_instr[gi][TS_W-1:0] - r_ts;
        assign w_elig[gi]    = r_valid[gi] & ((w_diff == '0) | w_diff[TS_W-1]);
        assign w_q[gi][0]    = r_instr[gi][OP1_OFS +: QBW];
        assign w_q[gi][1]    = r_instr[gi][OP2_OFS +: QBW];
        assign w_q[gi][2]    = r_instr[gi][DEST_OFS +: QBW];
        assign w_ins_mask[gi] = w_ins & (w_ins_idx == IDX_W'(gi));
    end

    always_comb begin
        logic [DEPTH-1:0]  granted;
        logic [NUM_FU-1:0] taken;
        logic [OCC_W-1:0]  cnt;
        logic              clash;
        logic              placed;
        granted = '0;
        taken   = '0;
        cnt     = '0;
        clash   = 1'b0;
        placed  = 1'b0;
        for (int k = 0; k < NUM_FU; k++) w_load_sel[k] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            clash = 1'b0;
            for (int j = 0; j < DEPTH; j++)
                if (j < i && granted[j])
                    for (int a = 0; a < 3; a++)
                        for (int b = 0; b < 3; b++)
                            if (w_q[i][a] == w_q[j][b]) clash = 1'b1;
            placed = 1'b0;
            if (w_elig[i] && !clash)
                for (int k = 0; k < NUM_FU; k++)
                    if (!placed && w_slot_free[k] && !taken[k]) begin
                        taken[k]      = 1'b1;
                        placed        = 1'b1;
                        w_load_sel[k] = IDX_W'(i);
                    end
            granted[i] = placed;
            if (placed) cnt = cnt + OCC_W'(1);
        end
        w_grant     = granted;
        w_load      = taken;
        w_grant_cnt = cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_ts    <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= (r_valid & ~w_grant) | w_ins_mask;
            r_occ   <= r_occ + OCC_W'(w_ins) - w_grant_cnt;
            if (w_ts_adv) r_ts <= r_ts + TS_W'(1);
        end
    end

    // Payload storage needs no reset; validity lives in r_valid.
    always_ff @(posedge clk) begin
        if (w_ins) r_instr[w_ins_idx] <= in_instr;
    end

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
        assign w_load_instr[gi] = r_instr[w_load_sel[gi]];

        qcs_fu_slot #(
            .INSTR_W (INSTR_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[gi]),
            .i_instr (w_load_instr[gi]),
            .i_ready (fu_ready[gi]),
            .o_valid (fu_valid[gi]),
            .o_instr (fu_instr[gi]),
            .o_free  (w_slot_free[gi])
        );
    end

endmodule

// File: tb/tb_qcs_dispatch_arbiter.sv
// Scoreboard bench for qcs_dispatch_arbiter: directed gates in, per-slot accepts checked by a monitor.
module tb_qcs_dispatch_arbiter;
    import qcs_pkg::*;

    // Narrow timestamp keeps the wrap scenario short.
    localparam int TB_NUM_FU = 4;
    localparam int TB_DEPTH  = 8;
    localparam int TB_TS_W   = 8;
    localparam int TB_QW     = qcs_qw(64, 64);
    localparam int TB_IW     = qcs_iw(TB_QW, TB_TS_W);
    localparam int TB_OCC_W  = $clog2(TB_DEPTH + 1);

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              in_valid;
    logic                              in_ready;
    logic [TB_IW-1:0]                  in_instr;
    logic [TB_NUM_FU-1:0]              fu_valid;
    logic [TB_NUM_FU-1:0]              fu_ready;
    logic [TB_NUM_FU-1:0][TB_IW-1:0]   fu_instr;
    logic                              ts_adv_en;
    logic [TB_TS_W-1:0]                curr_ts;
    logic [TB_OCC_W-1:0]               occupancy;
    logic                              idle;

    typedef struct {
        int               slot;
        logic [TB_IW-1:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    qcs_dispatch_arbiter #(
        .NUM_FPGA           (64),
        .NUM_QUBIT_PER_FPGA (64),
        .DEPTH              (TB_DEPTH),
        .NUM_FU             (TB_NUM_FU),
        .TS_W               (TB_TS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_instr  (fu_instr),
        .ts_adv_en (ts_adv_en),
        .curr_ts   (curr_ts),
        .occupancy (occupancy),
        .idle      (idle)
    );

    function automatic logic [TB_IW-1:0] mk(input int op, input int o1, input int o2,
                                            input int d, input int ts);
        return {2'(op), TB_QW'(o1), TB_QW'(o2), TB_QW'(d), TB_TS_W'(ts)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int slot, input logic [TB_IW-1:0] w);
        exp_t e;
        e.slot  = slot;
        e.instr = w;
        sb_q.push_back(e);
    endtask

    // Monitor: every accepted slot (valid & ready at the coming edge) is one transaction.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < TB_NUM_FU; k++) begin
                if (fu_valid[k] && fu_ready[k]) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_unexpected: slot %0d instr 0x%0h accepted, nothing expected",
                                 k, fu_instr[k]);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.slot != k || e.instr !== fu_instr[k]) begin
                            n_errors++;
                            $display("FAIL sb_accept: got slot %0d instr 0x%0h, expected slot %0d instr 0x%0h",
                                     k, fu_instr[k], e.slot, e.instr);
                        end else begin
                            $display("accept slot %0d instr 0x%0h at %0t", k, fu_instr[k], $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TB_IW-1:0] a_w, b_w, c_w, d_w, e_w, h_w, l_w, j_w, x_w;
        logic [TB_IW-1:0] f_w [4];
        logic [TB_IW-1:0] g_w [12];
        int guard;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        fu_ready  = '0;
        ts_adv_en = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_idle", 64'(idle), 1);
        chk("rst_curr_ts", 64'(curr_ts), 0);
        chk("rst_fu_valid", 64'(fu_valid), 0);
        chk("rst_occupancy", 64'(occupancy), 0);

        // Single issue: two cycles from accept to fu_valid.
        a_w = mk(1, 3, 4, 5, 0);
        push(0, a_w);
        in_valid = 1'b1;
        in_instr = a_w;
        tick();
        in_valid = 1'b0;
        chk("single_not_yet", 64'(fu_valid), 0);
        chk("single_occ", 64'(occupancy), 1);
        tick();
        chk("single_valid", 64'(fu_valid), 4'b0001);
        chk("single_instr", 64'(fu_instr[0]), 64'(a_w));
        fu_ready = '1;
        tick();
        chk("single_cleared", 64'(fu_valid), 0);
        chk("single_idle", 64'(idle), 1);

        // Conflict: fill all slots, then A/B/C queue up; B shares qubit 5 with A.
        fu_ready = '0;
        b_w = mk(2, 5, 6, 7, 0);
        c_w = mk(2, 8, 9, 10, 0);
        for (int i = 0; i < 4; i++) begin
            f_w[i] = mk(0, 100 + 3 * i, 101 + 3 * i, 102 + 3 * i, 0);
            push(i, f_w[i]);
        end
        push(0, a_w);
        push(1, c_w);
        push(0, b_w);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = f_w[i];
            tick();
        end
        in_instr = a_w; tick();
        in_instr = b_w; tick();
        in_instr = c_w; tick();
        in_valid = 1'b0;
        chk("conf_occ_3", 64'(occupancy), 3);
        chk("conf_slots_full", 64'(fu_valid), 4'b1111);
        fu_ready = '1;
        tick();
        chk("conf_pair_valid", 64'(fu_valid), 4'b0011);
        chk("conf_slot0_a", 64'(fu_instr[0]), 64'(a_w));
        chk("conf_slot1_c", 64'(fu_instr[1]), 64'(c_w));
        chk("conf_occ_1", 64'(occupancy), 1);
        tick();
        chk("conf_b_valid", 64'(fu_valid), 4'b0001);
        chk("conf_b_instr", 64'(fu_instr[0]), 64'(b_w));
        tick();
        chk("conf_idle", 64'(idle), 1);

        // Timestamp ordering and the time-step barrier.
        fu_ready = '0;
        d_w = mk(1, 50, 51, 52, 2);
        e_w = mk(1, 60, 61, 62, 0);
        push(0, e_w);
        push(0, d_w);
        in_valid = 1'b1;
        in_instr = d_w; tick();
        in_instr = e_w; tick();
        in_valid = 1'b0;
        chk("ts_nothing_yet", 64'(fu_valid), 0);
        tick();
        chk("ts_e_valid", 64'(fu_valid), 4'b0001);
        chk("ts_e_instr", 64'(fu_instr[0]), 64'(e_w));
        ts_adv_en = 1'b1;
        tick();
        tick();
        chk("ts_held_no_adv", 64'(curr_ts), 0);
        chk("ts_held_instr", 64'(fu_instr[0]), 64'(e_w));
        chk("ts_held_valid", 64'(fu_valid), 4'b0001);
        fu_ready = '1;
        tick();
        chk("ts_accept_no_adv", 64'(curr_ts), 0);
        chk("ts_e_cleared", 64'(fu_valid), 0);
        tick();
        chk("ts_adv_1", 64'(curr_ts), 1);
        tick();
        chk("ts_adv_2", 64'(curr_ts), 2);
        chk("ts_d_not_yet", 64'(fu_valid), 0);
        tick();
        chk("ts_d_valid", 64'(fu_valid), 4'b0001);
        chk("ts_d_instr", 64'(fu_instr[0]), 64'(d_w));
        chk("ts_stay_2", 64'(curr_ts), 2);
        ts_adv_en = 1'b0;
        tick();
        chk("ts_idle", 64'(idle), 1);

        // Full buffer with backpressure; start_time 0 is late at curr_ts 2.
        fu_ready = '0;
        for (int i = 0; i < 12; i++) begin
            g_w[i] = mk(3, 200 + 3 * i, 201 + 3 * i, 202 + 3 * i, 0);
            push(i % 4, g_w[i]);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_instr = g_w[i];
            chk($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_full_not_ready", 64'(in_ready), 0);
        chk("bp_full_occ", 64'(occupancy), 8);
        chk("bp_slots_full", 64'(fu_valid), 4'b1111);
        x_w = mk(0, 300, 301, 302, 0);
        in_valid = 1'b1;
        in_instr = x_w;
        tick();
        tick();
        in_valid = 1'b0;
        chk("bp_overflow_ignored", 64'(occupancy), 8);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_held_%0d", k), 64'(fu_instr[k]), 64'(g_w[k]));
        fu_ready = '1;
        tick();
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_drain1_%0d", k), 64'(fu_instr[k]), 64'(g_w[4 + k]));
        chk("bp_drain1_occ", 64'(occupancy), 4);
        chk("bp_drain1_ready", 64'(in_ready), 1);
        tick();
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_drain2_%0d", k), 64'(fu_instr[k]), 64'(g_w[8 + k]));
        chk("bp_drain2_occ", 64'(occupancy), 0);
        tick();
        chk("bp_idle", 64'(idle), 1);

        // Wrap: advance to 0xFF, then a future entry (ts 0) and a late one (ts 0xFE).
        ts_adv_en = 1'b1;
        guard = 0;
        while (curr_ts != 8'hFF && guard < 400) begin
            tick();
            guard++;
        end
        ts_adv_en = 1'b0;
        chk("wrap_reach_ff", 64'(curr_ts), 8'hFF);
        fu_ready = '0;
        h_w = mk(1, 20, 21, 22, 0);
        l_w = mk(1, 30, 31, 32, 8'hFE);
        j_w = mk(1, 40, 41, 42, 5);
        push(0, l_w);
        in_valid = 1'b1;
        in_instr = h_w; tick();
        in_instr = l_w; tick();
        in_valid = 1'b0;
        chk("wrap_none_yet", 64'(fu_valid), 0);
        tick();
        chk("wrap_late_valid", 64'(fu_valid), 4'b0001);
        chk("wrap_late_instr", 64'(fu_instr[0]), 64'(l_w));
        chk("wrap_future_buffered", 64'(occupancy), 1);
        ts_adv_en = 1'b1;
        fu_ready  = '1;
        tick();
        chk("wrap_accept_no_adv", 64'(curr_ts), 8'hFF);
        chk("wrap_future_not_elig", 64'(fu_valid), 0);
        tick();
        chk("wrap_to_zero", 64'(curr_ts), 0);
        fu_ready  = '0;
        ts_adv_en = 1'b0;
        tick();
        chk("wrap_h_valid", 64'(fu_valid), 4'b0001);
        chk("wrap_h_instr", 64'(fu_instr[0]), 64'(h_w));
        in_valid = 1'b1;
        in_instr = j_w;
        tick();
        in_valid = 1'b0;
        chk("mid_occ", 64'(occupancy), 1);
        chk("mid_valid", 64'(fu_valid), 4'b0001);

        // Asynchronous reset mid-cycle: outputs clear without waiting for a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_fu_valid", 64'(fu_valid), 0);
        chk("arst_fu_instr0", 64'(fu_instr[0]), 0);
        chk("arst_curr_ts", 64'(curr_ts), 0);
        chk("arst_occ", 64'(occupancy), 0);
        chk("arst_in_ready", 64'(in_ready), 1);
        chk("arst_idle", 64'(idle), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(idle), 1);
        chk("post_rst_fu_valid", 64'(fu_valid), 0);
        chk("sb_drained", 64'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
